// File: rtl/dm_hart_ctrl.sv
// Debug Module side halt/resume/register-access controller for one hart.
// Drives the core's dm_* handshake and reports status and abstract command results.
module dm_hart_ctrl #(
   parameter int unsigned ACCESS_CYCLES = 2,
   parameter int unsigned TIMEOUT       = 1023
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        cmd_halt_req_i,
   input  logic        cmd_resume_req_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic        cmd_write_i,
   input  logic [15:0] cmd_regno_i,
   input  logic [31:0] cmd_data_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_data_o,
   output logic [2:0]  rsp_err_o,
   output logic        status_halted_o,
   output logic        status_resumeack_o,
   output logic        status_ebreak_o,
   output logic        status_unavail_o,
   output logic        core_halt_req_o,
   input  logic        core_halt_ack_i,
   input  logic        core_resume_ack_i,
   input  logic        core_ebreak_i,
   input  logic        core_step_exec_i,
   output logic        core_reg_rd_wr_en_o,
   output logic        core_reg_rd_wr_o,
   output logic [15:0] core_reg_rd_wr_address_o,
   output logic [31:0] core_reg_data_o,
   output logic        core_reg_data_oe_o,
   input  logic [31:0] core_reg_data_i
);

   // state       | meaning
   // ST_RUNNING  | hart running, commands answered with err 4
   // ST_HALTING  | halt requested, waiting for halt_ack
   // ST_HALTED   | hart halted, register commands accepted
   // ST_ACCESS   | register access in progress on the core port
   // ST_RESUMING | resume requested, waiting for resume_ack
   typedef enum logic [2:0] {
      ST_RUNNING,
      ST_HALTING,
      ST_HALTED,
      ST_ACCESS,
      ST_RESUMING
   } state_t;

   localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT - 1);
   localparam logic [3:0]  ACC_LOAD = 4'(ACCESS_CYCLES - 1);

   state_t      state_q, state_d;
   logic [15:0] timer_q, timer_d;
   logic [3:0]  acc_cnt_q, acc_cnt_d;
   logic        pending_q, pending_d;
   logic        ready_q, ready_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_data_q, rsp_data_d;
   logic [2:0]  rsp_err_q, rsp_err_d;
   logic        halted_q, halted_d;
   logic        resumeack_q, resumeack_d;
   logic        ebreak_q, ebreak_d;
   logic        unavail_q, unavail_d;
   logic        halt_req_q, halt_req_d;
   logic        en_q, en_d;
   logic        rd_wr_q, rd_wr_d;
   logic [15:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        oe_q, oe_d;

   logic cmd_fire;
   logic regno_ok;

   assign cmd_fire = cmd_valid_i && ready_q;
   assign regno_ok = ((cmd_regno_i >= 16'h1000) && (cmd_regno_i <= 16'h101F)) ||
                     ((cmd_regno_i >= 16'h07B0) && (cmd_regno_i <= 16'h07B3));

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      acc_cnt_d   = acc_cnt_q;
      pending_d   = pending_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      halted_d    = halted_q;
      resumeack_d = resumeack_q;
      ebreak_d    = ebreak_q;
      unavail_d   = unavail_q;
      halt_req_d  = halt_req_q;
      en_d        = en_q;
      rd_wr_d     = rd_wr_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      oe_d        = oe_q;

      case (state_q)
         ST_RUNNING: begin
            if (cmd_fire) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = 3'd4;
            end
            // self-halt or step completion wins over a fresh haltreq
            if (core_halt_ack_i || core_ebreak_i) begin
               state_d    = ST_HALTED;
               halted_d   = 1'b1;
               halt_req_d = 1'b1;
               if (core_ebreak_i) ebreak_d = 1'b1;
            end else if (cmd_halt_req_i) begin
               state_d    = ST_HALTING;
               halt_req_d = 1'b1;
               timer_d    = TMO_LOAD;
            end
         end
         ST_HALTING: begin
            if (core_halt_ack_i) begin
               state_d  = ST_HALTED;
               halted_d = 1'b1;
               if (core_ebreak_i) ebreak_d = 1'b1;
            end else if (timer_q == 16'd0) begin
               unavail_d = 1'b1;
            end else begin
               timer_d = timer_q - 16'd1;
            end
         end
         ST_HALTED: begin
            pending_d = 1'b0;
            if (cmd_fire && regno_ok) begin
               state_d   = ST_ACCESS;
               acc_cnt_d = ACC_LOAD;
               pending_d = cmd_resume_req_i;
               en_d      = 1'b1;
               rd_wr_d   = cmd_write_i;
               addr_d    = cmd_regno_i;
               wdata_d   = cmd_write_i ? cmd_data_i : 32'd0;
               oe_d      = cmd_write_i;
            end else begin
               if (cmd_fire) begin
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 3'd2;
               end
               if ((cmd_resume_req_i || pending_q) && !cmd_halt_req_i) begin
                  state_d     = ST_RESUMING;
                  halt_req_d  = 1'b0;
                  resumeack_d = 1'b0;
                  ebreak_d    = 1'b0;
                  timer_d     = TMO_LOAD;
               end
            end
         end
         ST_ACCESS: begin
            if (cmd_resume_req_i) pending_d = 1'b1;
            if (acc_cnt_q == 4'd0) begin
               state_d     = ST_HALTED;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 3'd0;
               if (!rd_wr_q) rsp_data_d = core_reg_data_i;
               en_d        = 1'b0;
               rd_wr_d     = 1'b0;
               addr_d      = 16'd0;
               wdata_d     = 32'd0;
               oe_d        = 1'b0;
            end else begin
               acc_cnt_d = acc_cnt_q - 4'd1;
            end
         end
         ST_RESUMING: begin
            if (core_resume_ack_i) begin
               state_d     = ST_RUNNING;
               resumeack_d = 1'b1;
               halted_d    = 1'b0;
            end else if (timer_q == 16'd0) begin
               unavail_d = 1'b1;
            end else begin
               timer_d = timer_q - 16'd1;
            end
         end
         default: state_d = ST_RUNNING;
      endcase

      ready_d = (state_d == ST_RUNNING) || (state_d == ST_HALTED);
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q     <= ST_RUNNING;
         timer_q     <= 16'd0;
         acc_cnt_q   <= 4'd0;
         pending_q   <= 1'b0;
         ready_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 32'd0;
         rsp_err_q   <= 3'd0;
         halted_q    <= 1'b0;
         resumeack_q <= 1'b0;
         ebreak_q    <= 1'b0;
         unavail_q   <= 1'b0;
         halt_req_q  <= 1'b0;
         en_q        <= 1'b0;
         rd_wr_q     <= 1'b0;
         addr_q      <= 16'd0;
         wdata_q     <= 32'd0;
         oe_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         acc_cnt_q   <= acc_cnt_d;
         pending_q   <= pending_d;
         ready_q     <= ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         halted_q    <= halted_d;
         resumeack_q <= resumeack_d;
         ebreak_q    <= ebreak_d;
         unavail_q   <= unavail_d;
         halt_req_q  <= halt_req_d;
         en_q        <= en_d;
         rd_wr_q     <= rd_wr_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         oe_q        <= oe_d;
      end
   end

   assign cmd_ready_o              = ready_q;
   assign rsp_valid_o              = rsp_valid_q;
   assign rsp_data_o               = rsp_data_q;
   assign rsp_err_o                = rsp_err_q;
   assign status_halted_o          = halted_q;
   assign status_resumeack_o       = resumeack_q;
   assign status_ebreak_o          = ebreak_q;
   assign status_unavail_o         = unavail_q;
   assign core_halt_req_o          = halt_req_q;
   assign core_reg_rd_wr_en_o      = en_q;
   assign core_reg_rd_wr_o         = rd_wr_q;
   assign core_reg_rd_wr_address_o = addr_q;
   assign core_reg_data_o          = wdata_q;
   assign core_reg_data_oe_o       = oe_q;

   // step completion is reported to the DM only through the later halt_ack
   logic unused_step;
   assign unused_step = core_step_exec_i;

endmodule

// File: tb/tb_dm_hart_ctrl.sv
// Directed bench for dm_hart_ctrl: halt/resume, register access, error codes,
// ebreak, ack timeout and asynchronous reset during an access.
module tb_dm_hart_ctrl;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        cmd_halt_req_i, cmd_resume_req_i, cmd_valid_i, cmd_ready_o, cmd_write_i;
   logic [15:0] cmd_regno_i;
   logic [31:0] cmd_data_i;
   logic        rsp_valid_o;
   logic [31:0] rsp_data_o;
   logic [2:0]  rsp_err_o;
   logic        status_halted_o, status_resumeack_o, status_ebreak_o, status_unavail_o;
   logic        core_halt_req_o, core_halt_ack_i, core_resume_ack_i, core_ebreak_i, core_step_exec_i;
   logic        core_reg_rd_wr_en_o, core_reg_rd_wr_o, core_reg_data_oe_o;
   logic [15:0] core_reg_rd_wr_address_o;
   logic [31:0] core_reg_data_o, core_reg_data_i;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk_i = ~clk_i;

   dm_hart_ctrl #(.ACCESS_CYCLES(2), .TIMEOUT(8)) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .cmd_halt_req_i(cmd_halt_req_i), .cmd_resume_req_i(cmd_resume_req_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
      .cmd_regno_i(cmd_regno_i), .cmd_data_i(cmd_data_i),
      .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
      .status_halted_o(status_halted_o), .status_resumeack_o(status_resumeack_o),
      .status_ebreak_o(status_ebreak_o), .status_unavail_o(status_unavail_o),
      .core_halt_req_o(core_halt_req_o), .core_halt_ack_i(core_halt_ack_i),
      .core_resume_ack_i(core_resume_ack_i), .core_ebreak_i(core_ebreak_i),
      .core_step_exec_i(core_step_exec_i),
      .core_reg_rd_wr_en_o(core_reg_rd_wr_en_o), .core_reg_rd_wr_o(core_reg_rd_wr_o),
      .core_reg_rd_wr_address_o(core_reg_rd_wr_address_o),
      .core_reg_data_o(core_reg_data_o), .core_reg_data_oe_o(core_reg_data_oe_o),
      .core_reg_data_i(core_reg_data_i)
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      reset_i = 1'b0;
      cmd_halt_req_i = 0; cmd_resume_req_i = 0; cmd_valid_i = 0; cmd_write_i = 0;
      cmd_regno_i = 16'h0; cmd_data_i = 32'h0;
      core_halt_ack_i = 0; core_resume_ack_i = 0; core_ebreak_i = 0; core_step_exec_i = 0;
      core_reg_data_i = 32'h0;
      tick(); tick();
      chk("rst_ready", cmd_ready_o, 0);
      chk("rst_halt_req", core_halt_req_o, 0);
      chk("rst_halted", status_halted_o, 0);
      chk("rst_en", core_reg_rd_wr_en_o, 0);
      chk("rst_rsp_data", rsp_data_o, 0);
      chk("rst_rsp_valid", rsp_valid_o, 0);
      reset_i = 1'b1;
      tick();
      chk("run_ready", cmd_ready_o, 1);

      // read while running -> err 4, no access
      cmd_valid_i = 1; cmd_write_i = 0; cmd_regno_i = 16'h1001;
      tick();
      cmd_valid_i = 0;
      chk("run_rsp_valid", rsp_valid_o, 1);
      chk("run_rsp_err", rsp_err_o, 4);
      chk("run_en", core_reg_rd_wr_en_o, 0);
      tick();
      chk("run_rsp_pulse", rsp_valid_o, 0);
      chk("run_en2", core_reg_rd_wr_en_o, 0);

      // halt with ack three cycles after the request
      cmd_halt_req_i = 1;
      tick();
      chk("halt_req_c1", core_halt_req_o, 1);
      chk("halting_ready", cmd_ready_o, 0);
      tick();
      tick();
      chk("halting_halted", status_halted_o, 0);
      core_halt_ack_i = 1;
      tick();
      core_halt_ack_i = 0;
      chk("halted", status_halted_o, 1);
      chk("halted_req_held", core_halt_req_o, 1);
      chk("halted_ready", cmd_ready_o, 1);
      cmd_halt_req_i = 0;

      // register read 0x1005
      core_reg_data_i = 32'hDEADBEEF;
      cmd_valid_i = 1; cmd_write_i = 0; cmd_regno_i = 16'h1005;
      tick();
      cmd_valid_i = 0;
      chk("rd_en_c1", core_reg_rd_wr_en_o, 1);
      chk("rd_addr", core_reg_rd_wr_address_o, 32'h1005);
      chk("rd_rdwr", core_reg_rd_wr_o, 0);
      chk("rd_oe", core_reg_data_oe_o, 0);
      chk("rd_ready", cmd_ready_o, 0);
      tick();
      chk("rd_en_c2", core_reg_rd_wr_en_o, 1);
      chk("rd_rsp_early", rsp_valid_o, 0);
      tick();
      chk("rd_en_c3", core_reg_rd_wr_en_o, 0);
      chk("rd_rsp_valid", rsp_valid_o, 1);
      chk("rd_rsp_data", rsp_data_o, 32'hDEADBEEF);
      chk("rd_rsp_err", rsp_err_o, 0);
      tick();
      chk("rd_rsp_pulse", rsp_valid_o, 0);

      // register write 0x07B1
      core_reg_data_i = 32'h12345678;
      cmd_valid_i = 1; cmd_write_i = 1; cmd_regno_i = 16'h07B1; cmd_data_i = 32'h80000010;
      tick();
      cmd_valid_i = 0; cmd_write_i = 0; cmd_data_i = 32'h0;
      chk("wr_en_c1", core_reg_rd_wr_en_o, 1);
      chk("wr_rdwr", core_reg_rd_wr_o, 1);
      chk("wr_oe_c1", core_reg_data_oe_o, 1);
      chk("wr_data", core_reg_data_o, 32'h80000010);
      chk("wr_addr", core_reg_rd_wr_address_o, 32'h07B1);
      tick();
      chk("wr_en_c2", core_reg_rd_wr_en_o, 1);
      chk("wr_oe_c2", core_reg_data_oe_o, 1);
      tick();
      chk("wr_en_c3", core_reg_rd_wr_en_o, 0);
      chk("wr_oe_c3", core_reg_data_oe_o, 0);
      chk("wr_rsp_valid", rsp_valid_o, 1);
      chk("wr_rsp_err", rsp_err_o, 0);
      chk("wr_rsp_data_kept", rsp_data_o, 32'hDEADBEEF);
      tick();

      // invalid regno while halted -> err 2
      cmd_valid_i = 1; cmd_write_i = 0; cmd_regno_i = 16'h2000;
      tick();
      cmd_valid_i = 0;
      chk("inv_rsp_valid", rsp_valid_o, 1);
      chk("inv_rsp_err", rsp_err_o, 2);
      chk("inv_en", core_reg_rd_wr_en_o, 0);
      chk("inv_data_kept", rsp_data_o, 32'hDEADBEEF);
      tick();

      // resume pulse during an access is applied on return to HALTED
      core_reg_data_i = 32'hA5A5A5A5;
      cmd_valid_i = 1; cmd_write_i = 0; cmd_regno_i = 16'h07B0;
      tick();
      cmd_valid_i = 0;
      cmd_resume_req_i = 1;
      tick();
      cmd_resume_req_i = 0;
      chk("pend_halt_req", core_halt_req_o, 1);
      tick();
      chk("pend_rsp_valid", rsp_valid_o, 1);
      chk("pend_rsp_data", rsp_data_o, 32'hA5A5A5A5);
      chk("pend_still_req", core_halt_req_o, 1);
      tick();
      chk("resuming_req", core_halt_req_o, 0);
      chk("resuming_halted", status_halted_o, 1);
      chk("resuming_ack", status_resumeack_o, 0);
      core_resume_ack_i = 1;
      tick();
      core_resume_ack_i = 0;
      chk("resumed_ack", status_resumeack_o, 1);
      chk("resumed_halted", status_halted_o, 0);
      chk("resumed_ready", cmd_ready_o, 1);

      // ebreak self-halt, then resumereq masked by haltreq
      core_ebreak_i = 1;
      tick();
      core_ebreak_i = 0;
      chk("eb_halted", status_halted_o, 1);
      chk("eb_flag", status_ebreak_o, 1);
      chk("eb_halt_req", core_halt_req_o, 1);
      cmd_resume_req_i = 1; cmd_halt_req_i = 1;
      tick();
      cmd_resume_req_i = 0; cmd_halt_req_i = 0;
      chk("eb_masked_req", core_halt_req_o, 1);
      chk("eb_masked_flag", status_ebreak_o, 1);
      chk("eb_masked_ack", status_resumeack_o, 1);
      cmd_resume_req_i = 1;
      tick();
      cmd_resume_req_i = 0;
      chk("eb_res_req", core_halt_req_o, 0);
      chk("eb_res_flag", status_ebreak_o, 0);
      chk("eb_res_ack", status_resumeack_o, 0);
      core_resume_ack_i = 1;
      tick();
      core_resume_ack_i = 0;
      chk("eb_run_halted", status_halted_o, 0);

      // halt without ack -> unavail after 8 cycles
      cmd_halt_req_i = 1;
      tick();
      for (int i = 0; i < 4; i++) tick();
      chk("tmo_early", status_unavail_o, 0);
      for (int i = 0; i < 6; i++) tick();
      chk("tmo_unavail", status_unavail_o, 1);
      chk("tmo_not_halted", status_halted_o, 0);
      core_halt_ack_i = 1;
      tick();
      core_halt_ack_i = 0;
      chk("tmo_halted", status_halted_o, 1);
      chk("tmo_sticky", status_unavail_o, 1);
      cmd_halt_req_i = 0;

      // asynchronous reset in the middle of a write access
      cmd_valid_i = 1; cmd_write_i = 1; cmd_regno_i = 16'h1003; cmd_data_i = 32'h0000CAFE;
      tick();
      cmd_valid_i = 0; cmd_write_i = 0;
      chk("ra_en", core_reg_rd_wr_en_o, 1);
      chk("ra_oe", core_reg_data_oe_o, 1);
      #2;
      reset_i = 1'b0;
      #1;
      chk("ra_en_drop", core_reg_rd_wr_en_o, 0);
      chk("ra_oe_drop", core_reg_data_oe_o, 0);
      chk("ra_halt_req_drop", core_halt_req_o, 0);
      chk("ra_unavail_clr", status_unavail_o, 0);
      tick();
      reset_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("ra_no_rsp", rsp_valid_o, 0);
         chk("ra_no_en", core_reg_rd_wr_en_o, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
